// File: rtl/aes_key_expansion_seq.sv
// aes_key_expansion_seq: iterative AES-128 key schedule emitting round keys 0..10 over valid/ready.
// Define AES_KEY_STORE_EN to keep an 11-entry round-key store readable through rdIndex/rdKey.
module aes_key_expansion_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         keyReady,
  output logic [127:0] roundKey,
  output logic [3:0]   roundIndex,
  output logic         keyValid,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rdIndex,
  output logic [127:0] rdKey
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nx;
  logic [127:0] r_key, w_key_nx, w_next;
  logic [3:0] r_idx, w_idx_nx;
  logic r_done, w_done_nx;
  logic [31:0] w_rot, w_t;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s, r;
    s = b;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return i == 4'd8 ? 8'h1b : i == 4'd9 ? 8'h36 : 8'(8'h01 << i);
  endfunction
  assign w_rot = {r_key[23:0], r_key[31:24]};
  assign w_t = {sbox(w_rot[31:24]) ^ rcon(r_idx), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_next[127:96] = r_key[127:96] ^ w_t;
  assign w_next[95:64] = r_key[95:64] ^ w_next[127:96];
  assign w_next[63:32] = r_key[63:32] ^ w_next[95:64];
  assign w_next[31:0] = r_key[31:0] ^ w_next[63:32];
  always_comb begin
    w_state_nx = r_state;
    w_key_nx = r_key;
    w_idx_nx = r_idx;
    w_done_nx = 1'b0;
    if (r_state == IDLE && start) begin
      w_state_nx = RUN;
      w_key_nx = key;
      w_idx_nx = '0;
    end else if (r_state == RUN && keyReady) begin
      if (r_idx == 4'(NUM_ROUNDS)) begin
        w_state_nx = IDLE;
        w_done_nx = 1'b1;
      end else begin
        w_key_nx = w_next;
        w_idx_nx = r_idx + 4'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key <= '0;
      r_idx <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_key <= w_key_nx;
      r_idx <= w_idx_nx;
      r_done <= w_done_nx;
    end
  end
  assign roundKey = r_key;
  assign roundIndex = r_idx;
  assign keyValid = r_state == RUN;
  assign busy = r_state == RUN;
  assign done = r_done;
`ifdef AES_KEY_STORE_EN
  logic [127:0] r_store [0:10];
  // rewriting during a stall stores the same held key, so no write-once gating is needed
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 11; k++) r_store[k] <= '0;
      rdKey <= '0;
    end else begin
      if (r_state == RUN) r_store[r_idx] <= r_key;
      rdKey <= rdIndex <= 4'd10 ? r_store[rdIndex] : '0;
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rdIndex;
  assign rdKey = '0;
`endif
endmodule

// File: tb/tb_aes_key_expansion_seq.sv
// tb_aes_key_expansion_seq: scoreboarded bench for the iterative AES-128 key schedule.
module tb_aes_key_expansion_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, keyReady = 1'b1;
  logic [127:0] key = '0;
  logic [3:0] rdIndex = '0;
  logic [127:0] roundKey, rdKey;
  logic [3:0] roundIndex;
  logic keyValid, busy, done;
  aes_key_expansion_seq dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .keyReady(keyReady),
    .roundKey(roundKey), .roundIndex(roundIndex), .keyValid(keyValid), .busy(busy),
    .done(done), .rdIndex(rdIndex), .rdKey(rdKey)
  );
  always #5 clk = ~clk;
  typedef struct {logic [127:0] key; logic [3:0] idx; logic [127:0] rk;} vec_t;
  typedef struct {logic [3:0] idx; logic [127:0] rk; bit chk;} exp_t;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  vec_t vecs[6];
  exp_t q[$];
  logic [127:0] ref1[11];
  bit have_ref = 0, rec = 0, pv = 0;
  logic [127:0] pk;
  logic [3:0] pi;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic push_run(input logic [127:0] k);
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx = 4'(i);
      e.rk = '0;
      e.chk = 0;
      if (k == K1 && have_ref) begin
        e.rk = ref1[i];
        e.chk = 1;
      end
      foreach (vecs[v]) if (vecs[v].key == k && vecs[v].idx == 4'(i)) begin
        e.rk = vecs[v].rk;
        e.chk = 1;
      end
      q.push_back(e);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (pv) begin
      chk("stall_key", roundKey, pk);
      chk("stall_idx", 128'(roundIndex), 128'(pi));
    end
    if (keyValid === 1'b1 && keyReady) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake idx %0d got %h want none", roundIndex, roundKey);
      end else begin
        e = q.pop_front();
        chk("hs_idx", 128'(roundIndex), 128'(e.idx));
        if (e.chk) chk("hs_key", roundKey, e.rk);
      end
      if (rec) ref1[roundIndex] = roundKey;
    end
    pv = keyValid === 1'b1 && !keyReady;
    pk = roundKey;
    pi = roundIndex;
    @(posedge clk);
    #1;
  endtask
  task automatic run_until_done(input bit stall, input int expc);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      keyReady = stall ? (n % 4 == 0 || n % 4 == 3) : 1'b1;
      tick();
      n++;
    end
    keyReady = 1'b1;
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d cycles want done", n);
    end
    if (expc >= 0) chk("done_latency", 128'(n), 128'(expc));
    chk("done_q_empty", 128'(q.size()), 128'(0));
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_valid", 128'(keyValid), 128'(0));
  endtask
  task automatic wait_idx(input logic [3:0] t);
    int n = 0;
    while (roundIndex !== t && n < 20) begin
      tick();
      n++;
    end
    chk("wait_idx", 128'(roundIndex), 128'(t));
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_key"}, roundKey, '0);
    chk({tag, "_idx"}, 128'(roundIndex), '0);
    chk({tag, "_valid"}, 128'(keyValid), '0);
    chk({tag, "_busy"}, 128'(busy), '0);
    chk({tag, "_done"}, 128'(done), '0);
    chk({tag, "_rdkey"}, rdKey, '0);
  endtask
  task automatic do_start(input logic [127:0] k);
    start = 1'b1;
    key = k;
    push_run(k);
    tick();
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
  endtask
  initial begin
    vecs[0] = '{K1, 4'd0, K1};
    vecs[1] = '{K1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{K1, 4'd2, 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{K1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{K2, 4'd0, K2};
    vecs[5] = '{K2, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tick();
    tick();
    reset = 1'b0;
    check_zero("reset");
    rec = 1;
    do_start(K1);
    chk("r0_valid", 128'(keyValid), 128'(1));
    chk("r0_busy", 128'(busy), 128'(1));
    run_until_done(0, 11);
    rec = 0;
    have_ref = 1;
    tick();
    chk("done_pulse_one", 128'(done), 128'(0));
    rdIndex = 4'd1;
    tick();
`ifdef AES_KEY_STORE_EN
    chk("store_rd1", rdKey, vecs[1].rk);
`else
    chk("store_rd1", rdKey, '0);
`endif
    rdIndex = 4'd11;
    tick();
    chk("store_rd11", rdKey, '0);
    do_start(K1);
    run_until_done(1, -1);
    tick();
    do_start(K1);
    wait_idx(4'd4);
    start = 1'b1;
    key = K2;
    tick();
    start = 1'b0;
    chk("busy_ignore_busy", 128'(busy), 128'(1));
    chk("busy_ignore_idx", 128'(roundIndex), 128'(5));
    run_until_done(0, -1);
    tick();
    do_start(K1);
    wait_idx(4'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midreset");
    q.delete();
    do_start(K2);
    run_until_done(0, 11);
    do_start(K1);
    run_until_done(0, 11);
    start = 1'b1;
    key = K2;
    push_run(K2);
    tick();
    start = 1'b0;
    chk("donestart_valid", 128'(keyValid), 128'(1));
    chk("donestart_idx", 128'(roundIndex), 128'(0));
    chk("donestart_key", roundKey, K2);
    run_until_done(0, 11);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_expansion_seq.md
Name: aes_key_expansion_seq

Overview:
- Iterative AES-128 key schedule for the cipher datapath.
- Takes a 128-bit cipher key and emits round keys 0..10, one per handshake, on a valid/ready interface.
- Sits directly upstream of the AddRoundKey stage and drives its 128-bit roundKey operand.
- Uses one SubWord/RotWord/Rcon datapath reused across rounds; no precomputed tables of round keys unless the optional store is compiled in.

Parameters:
- NUM_ROUNDS, 10, last round index emitted. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin expansion of key; honoured only when busy=0.
- key  input  128  cipher key, FIPS-197 byte order (byte 0 in bits 127:120); sampled on an accepted start.
- keyReady  input  1  downstream accepts the current roundKey this cycle.
- roundKey  output  128  current round key w[4i..4i+3], same byte order as key.
- roundIndex  output  4  index i of roundKey, 0..10.
- keyValid  output  1  roundKey/roundIndex valid.
- busy  output  1  expansion in progress (start ignored).
- done  output  1  one-cycle pulse after round NUM_ROUNDS is accepted.
- rdIndex  input  4  optional-store read address (see Optional Feature).
- rdKey  output  128  optional-store read data.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; roundKey=0, roundIndex=0, keyValid=0, busy=0, done=0, rdKey=0. Reset wins over every other input in the same cycle, including mid-expansion; no partial key is retained.
- FSM states are IDLE and RUN.
- IDLE, start=1:
  - Next cycle: roundKey=key, roundIndex=0, keyValid=1, busy=1, state=RUN.
  - Latency from start to round 0 valid is 1 cycle.
- RUN, keyValid=1 and keyReady=0: stall. roundKey and roundIndex are held stable; no state change.
- RUN, handshake (keyValid and keyReady) with roundIndex<NUM_ROUNDS:
  - Next cycle: roundKey = next round key, roundIndex+1, keyValid stays 1.
  - Throughput is one key per cycle while keyReady=1.
- RUN, handshake with roundIndex=NUM_ROUNDS:
  - Next cycle: keyValid=0, busy=0, done=1 for exactly one cycle, state=IDLE.
  - roundKey and roundIndex hold their last values.
- Next-key arithmetic, with words w0..w3 of the current key (w0 = bits 127:96):
  - t = SubWord(RotWord(w3)) XOR {Rcon[i+1],24'h0}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - RotWord rotates bytes left by one.
  - SubWord applies the AES S-box to each of the 4 bytes, implemented combinationally inside the block.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, selected by roundIndex; there is no separate counter.
- start while busy=1 is ignored, including during the done cycle's preceding handshake.
- start in the done cycle (busy=0) is accepted and begins a new expansion.
- With keyReady held 1: start at cycle N gives round k valid at N+1+k and done at N+12.
- key changes after start are ignored; only the sampled value is used.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- Defined:
  - An 11x128 register file captures each roundKey when it becomes valid, indexed by roundIndex.
  - rdKey returns entry rdIndex with 1-cycle registered latency.
  - Entries persist after done until overwritten by the next expansion; reset clears all entries to 0.
  - rdIndex>10 reads 0.
  - Purpose: reverse-order key supply for decryption without re-expansion.
- Undefined: no storage is built; rdKey is constant 0 and rdIndex is unused. All other behaviour is identical.

Test Plan:
- Reset, start with key=2b7e151628aed2a6abf7158809cf4f3c, keyReady=1 -> round0=2b7e1516...cf4f3c at N+1; round1=a0fafe1788542cb123a339392a6c7605; round2=f2c295f27a96b9435935807a7359f67f; round10=d014f9a8c9ee2589e13f0cc8b6630ca6 at N+11; done pulse at N+12.
- Same key, keyReady toggled 1,0,0,1,... -> roundKey/roundIndex stable during every 0 cycle; the sequence of accepted keys is identical to the first test; done follows only the round-10 accept.
- start pulsed while busy at roundIndex=4, with a different key -> ignored; remaining keys match the original key; busy stays 1.
- reset asserted at roundIndex=6 -> next cycle all outputs 0, state IDLE. A following start with key=000102030405060708090a0b0c0d0e0f gives round10=13111d7fe3944a17f307a78b4d2b30c5.
- start asserted in the done cycle -> new expansion accepted; round0 appears one cycle later.
- AES_KEY_STORE_EN defined, after the first test, rdIndex=1 -> rdKey=a0fafe1788542cb123a339392a6c7605 one cycle later. rdIndex=11 -> 0. Macro undefined -> rdKey always 0.
